// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the pending-write entry type for the writeback path
package wb_pkg;
    localparam int REG_ADDRESS_SIZE = 3;
    localparam int REG_DATA_WIDTH = 8;
    typedef struct packed {
        logic [REG_ADDRESS_SIZE-1:0] addr;
        logic [REG_DATA_WIDTH-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer with ordered dual push, single pop and age-ordered entry view
module wb_fifo import wb_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0,
    input  wb_entry_t              d0,
    input  logic                   push1,
    input  wb_entry_t              d1,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output wb_entry_t              ent [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_entry_t mem [DEPTH];
    logic [PW-1:0] rd, wr, wr1;
    logic [1:0] n;
    logic do_pop;
    assign wr1 = wr + 1'b1;
    assign n = {1'b0, push0} + {1'b0, push1};
    assign do_pop = pop && count != '0;
    assign head = mem[rd];
    // push0 always takes the first free slot so it stays older than push1
    always_ff @(posedge clk) begin
        if (push0 || push1) mem[wr] <= push0 ? d0 : d1;
        if (push0 && push1) mem[wr1] <= d1;
    end
    // pointers and occupancy; count is separate so full and empty never alias
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            wr <= wr + PW'(n);
            rd <= rd + PW'(do_pop);
            count <= count + CW'(n) - CW'(do_pop);
        end
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        localparam logic [PW-1:0] OFF = PW'(i);
        assign ent[i] = mem[rd + OFF];
    end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU/load results into a pending-write buffer and drains it to the register file
module reg_writeback import wb_pkg::*; #(
    parameter int REG_ADDRESS_SIZE = wb_pkg::REG_ADDRESS_SIZE,
    parameter int REG_DATA_WIDTH   = wb_pkg::REG_DATA_WIDTH,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [REG_ADDRESS_SIZE-1:0]   alu_addr,
    input  logic [REG_DATA_WIDTH-1:0]     alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [REG_ADDRESS_SIZE-1:0]   mem_addr,
    input  logic [REG_DATA_WIDTH-1:0]     mem_data,
    output logic                          WR,
    output logic [REG_ADDRESS_SIZE-1:0]   DA,
    output logic [REG_DATA_WIDTH-1:0]     wb_data,
    input  logic [REG_ADDRESS_SIZE-1:0]   fwd_a_addr,
    output logic                          fwd_a_hit,
    output logic [REG_DATA_WIDTH-1:0]     fwd_a_data,
    input  logic [REG_ADDRESS_SIZE-1:0]   fwd_b_addr,
    output logic                          fwd_b_hit,
    output logic [REG_DATA_WIDTH-1:0]     fwd_b_data,
    output logic [$clog2(FIFO_DEPTH):0]   pending_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    wb_entry_t head;
    wb_entry_t ent [FIFO_DEPTH];
    logic [CW-1:0] free;
    logic mem_push, alu_push;
    assign free = CW'(FIFO_DEPTH) - pending_cnt + CW'(pending_cnt != '0);
    assign mem_ready = rst && free != '0;
    assign alu_ready = rst && free >= CW'(1) + CW'(mem_valid);
    assign mem_push = mem_valid && mem_ready && mem_addr != '0;
    assign alu_push = alu_valid && alu_ready && alu_addr != '0;
    assign WR = pending_cnt != '0;
    assign DA = WR ? head.addr : '0;
    assign wb_data = WR ? head.data : '0;
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (mem_push),
        .d0    ('{addr: mem_addr, data: mem_data}),
        .push1 (alu_push),
        .d1    ('{addr: alu_addr, data: alu_data}),
        .pop   (WR),
        .head  (head),
        .count (pending_cnt),
        .ent   (ent)
    );
    // scan oldest to youngest so the youngest matching entry wins
    always_comb begin
        fwd_a_hit = 1'b0;
        fwd_a_data = '0;
        fwd_b_hit = 1'b0;
        fwd_b_data = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < pending_cnt && fwd_a_addr != '0 && ent[i].addr == fwd_a_addr) begin
                fwd_a_hit = 1'b1;
                fwd_a_data = ent[i].data;
            end
            if (CW'(i) < pending_cnt && fwd_b_addr != '0 && ent[i].addr == fwd_b_addr) begin
                fwd_b_hit = 1'b1;
                fwd_b_data = ent[i].data;
            end
        end
    end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Write-side driver for the 8-entry register file. It accepts completed results from two producers, the ALU result path and the memory-load path, using valid/ready handshakes. Results are queued in a small in-order buffer and drained at one write per cycle onto the register file write port (WR/DA/data). It also gives decode a forwarding lookup for any buffered result that has not yet been written.

Parameters:
REG_ADDRESS_SIZE, 3, register address width
REG_DATA_WIDTH, 8, register data width
FIFO_DEPTH, 4, pending-write buffer entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low (0 = reset)
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle if alu_valid
alu_addr  in  REG_ADDRESS_SIZE  ALU destination register
alu_data  in  REG_DATA_WIDTH  ALU result
mem_valid  in  1  load result valid
mem_ready  out  1  load result accepted this cycle if mem_valid
mem_addr  in  REG_ADDRESS_SIZE  load destination register
mem_data  in  REG_DATA_WIDTH  load data
WR  out  1  register file write enable
DA  out  REG_ADDRESS_SIZE  register file write address
wb_data  out  REG_DATA_WIDTH  register file write data
fwd_a_addr  in  REG_ADDRESS_SIZE  lookup address A (decode AA)
fwd_a_hit  out  1  pending write to fwd_a_addr exists
fwd_a_data  out  REG_DATA_WIDTH  youngest pending data for fwd_a_addr
fwd_b_addr, fwd_b_hit, fwd_b_data  same as A for port B
pending_cnt  out  log2(FIFO_DEPTH)+1  number of buffered entries

Behaviour:
- Reset (rst=0, asynchronous): buffer emptied. WR=0, DA=0, wb_data=0, fwd_*_hit=0, fwd_*_data=0, pending_cnt=0, alu_ready=0, mem_ready=0 immediately. All outputs hold these values while rst=0. After release, the first posedge operates normally.
- Drain: when the buffer is non-empty, WR=1 and DA/wb_data are combinational from the head entry. The register file always accepts, so the head pops at every posedge where count>0. When the buffer is empty, WR=0, DA=0, wb_data=0.
- Latency: a result accepted at posedge N appears on WR/DA/wb_data during cycle N+1 if the buffer was empty. The register file commits it at posedge N+1.
- Free slots: free = FIFO_DEPTH - count + (count!=0), because the pop happens in the same cycle.
- Ready rules (combinational, no dependence on the other producer's ready):
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 1 + mem_valid).
  - The memory path has priority.
- Ordering: when both producers are accepted in the same cycle, the mem entry is enqueued before the alu entry, because the load is the older instruction. Otherwise entries are kept strictly in acceptance order.
- R0 filter: a result with addr=0 is handshaken (ready per the rules above) but discarded. It is not enqueued, does not consume a slot in that cycle, and never raises WR.
- Forwarding:
  - Purely combinational over the stored entries only; results being accepted in the current cycle are not included.
  - hit=1 if any valid entry matches the lookup address. data = youngest matching entry.
  - Lookup address 0 always gives hit=0, data=0. No hit gives data=0.
  - The head entry being written this cycle still counts as a hit.
- Full buffer: count=FIFO_DEPTH gives free=1. mem can enqueue; alu_ready=1 only if mem_valid=0.
- Overflow and underflow are impossible by construction. Enqueueing with ready=0 is a protocol error: the input is ignored and state is unchanged.
- Pointers wrap modulo FIFO_DEPTH. count is kept separately so that full and empty are unambiguous.

Decomposition:
- Shared package wb_pkg holds REG_ADDRESS_SIZE and REG_DATA_WIDTH defaults and the entry struct {addr, data}.
- One sub-module, wb_fifo: circular buffer with dual push (ordered), single pop, count output, and parallel entry visibility for the forwarding CAM.
- Arbitration, the R0 filter and forwarding priority logic stay in reg_writeback.

Test Plan:
- Reset mid-drain:
  - Stimulus: 3 entries queued, then rst=0 asynchronously between edges.
  - Response: WR=0 and pending_cnt=0 immediately. After release, no stale writes.
- Single ALU result:
  - Stimulus: alu addr=3, data=0x5A at posedge N.
  - Response: cycle N+1 shows WR=1, DA=3, wb_data=0x5A. Cycle N+2 shows WR=0.
- Simultaneous push:
  - Stimulus: mem (2, 0x11) and alu (2, 0x22) in the same cycle.
  - Response: writes appear in order 0x11 then 0x22 on DA=2. fwd_a_addr=2 returns 0x22 while both are pending.
- Full buffer backpressure:
  - Stimulus: fill to 4 with both producers valid.
  - Response: mem_ready=1, alu_ready=0. pending_cnt never exceeds 4. All accepted writes drain in order.
- R0 discard:
  - Stimulus: alu addr=0, data=0xFF accepted.
  - Response: WR stays 0, pending_cnt unchanged, fwd lookup of addr 0 gives hit=0.
- Forward after drain:
  - Stimulus: single entry (5, 0x33).
  - Response: fwd hit=1 during cycle N+1, hit=0 from cycle N+2.
